id_inst_queue: RTL and testbench

- Parametrised instruction queue between the IF stage and the ID decode stage of the LoongArch pipeline.
- Replaces the single-entry IF/ID latch with a DEPTH-entry FIFO of {pc, inst, exception type} records, so fetch keeps running while ID stalls on a data hazard.
- Uses the same valid/allowin handshake style as the other pipeline stages.
- Supports a one-cycle flush driven by the ID jump flag or by the exception/ertn redirect.

---
 rtl/id_inst_queue.sv | 76 +++++++
 tb/tb_id_inst_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/id_inst_queue.sv
// id_inst_queue: DEPTH-entry FIFO of {pc, inst, exc} records between IF and ID.
// Ports: IF side if_to_iq_valid_i/iq_allowin_o/pc_inst_ibus/excep_type_i;
// ID side iq_to_id_valid_o/id_allowin_i/pc_inst_obus/excep_type_o;
// status count_o/full_o/empty_o; flush_i drops every entry.
// Optional macro ID_IQ_BYPASS_EN: an empty queue forwards the IF record combinationally.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      if_to_iq_valid_i,
  output logic                      iq_allowin_o,
  input  logic [PC_W+INST_W-1:0]    pc_inst_ibus,
  input  logic [EXC_W-1:0]          excep_type_i,
  input  logic                      id_allowin_i,
  output logic                      iq_to_id_valid_o,
  output logic [PC_W+INST_W-1:0]    pc_inst_obus,
  output logic [EXC_W-1:0]          excep_type_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = PC_W + INST_W + EXC_W;
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic push, pop, byp;
  logic [RW-1:0] head;
  // A bypassed record that ID takes at once is also pushed and popped, so both
  // pointers advance together and the count stays at zero.
  always_comb begin
    byp = 1'b0;
`ifdef ID_IQ_BYPASS_EN
    byp = empty_q && !flush_i;
`endif
    head = byp ? {pc_inst_ibus, excep_type_i} : (empty_q ? '0 : mem_q[rd_ptr_q]);
    iq_allowin_o = !full_q;
    iq_to_id_valid_o = byp ? if_to_iq_valid_i : !empty_q;
    push = if_to_iq_valid_i && iq_allowin_o;
    pop = iq_to_id_valid_o && id_allowin_i;
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    full_d = count_d == CW'(DEPTH);
    empty_d = count_d == '0;
  end
  assign pc_inst_obus = head[RW-1:EXC_W];
  assign excep_type_o = head[EXC_W-1:0];
  assign count_o = count_q;
  assign full_o = full_q;
  assign empty_o = empty_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  always_ff @(posedge clk)
    if (push && !flush_i) mem_q[wr_ptr_q] <= {pc_inst_ibus, excep_type_i};
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: queue-model checking of id_inst_queue under directed and random traffic.
module tb_id_inst_queue;
  localparam int DEPTH = 4;
  logic clk, rst_n, flush, vin, ida, allow, vout, full, empty;
  logic [63:0] pci, pco;
  logic [7:0] exi, exo;
  logic [2:0] cnt;
  int vectors = 0, errors = 0;
  logic [71:0] q [$];
  id_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .if_to_iq_valid_i(vin), .iq_allowin_o(allow),
    .pc_inst_ibus(pci), .excep_type_i(exi),
    .id_allowin_i(ida), .iq_to_id_valid_o(vout),
    .pc_inst_obus(pco), .excep_type_o(exo),
    .count_o(cnt), .full_o(full), .empty_o(empty)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Called at a falling edge: applies inputs, checks outputs against the queue
  // model, then advances the model across the next rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [7:0] ex,
                      input logic id, input logic fl, input logic rn);
    int n;
    logic byp, e_allow, e_valid, push, pop;
    logic [71:0] e_head;
    vin = v; pci = {pc, 32'($urandom)}; exi = ex; ida = id; flush = fl; rst_n = rn;
    #1;
    n = q.size();
    byp = 1'b0;
`ifdef ID_IQ_BYPASS_EN
    byp = (n == 0) && !fl;
`endif
    e_allow = n < DEPTH;
    e_valid = byp ? v : (n > 0);
    e_head = byp ? {pci, exi} : (n > 0 ? q[0] : 72'd0);
    chk("allowin", 72'(allow), 72'(e_allow));
    chk("valid", 72'(vout), 72'(e_valid));
    chk("head", {pco, exo}, e_head);
    chk("count", 72'(cnt), 72'(n));
    chk("full", 72'(full), 72'(n == DEPTH));
    chk("empty", 72'(empty), 72'(n == 0));
    push = v && e_allow;
    pop = e_valid && id;
    @(posedge clk);
    if (!rn || fl) q.delete();
    else if (!(byp && pop)) begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({pci, exi});
    end
    @(negedge clk);
  endtask
  task automatic idle();
    vin = 1'b0; ida = 1'b0; flush = 1'b0; rst_n = 1'b1;
    #1;
  endtask
  initial begin
    vin = 0; ida = 0; flush = 0; rst_n = 0; pci = '0; exi = '0;
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("rst_count", 72'(cnt), 72'd0);
    chk("rst_empty", 72'(empty), 72'd1);
    chk("rst_full", 72'(full), 72'd0);
    chk("rst_allowin", 72'(allow), 72'd1);
    chk("rst_valid", 72'(vout), 72'd0);
    chk("rst_head", {pco, exo}, 72'd0);
    for (int i = 0; i < 3; i++) step(1, 32'h1c000000 + 32'(4 * i), 8'h00, 1, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 32'h0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h1c000000 + 32'(4 * i), 8'h00, 0, 0, 1);
    idle();
    chk("fill_count", 72'(cnt), 72'd4);
    chk("fill_full", 72'(full), 72'd1);
    chk("fill_allowin", 72'(allow), 72'd0);
    chk("fill_head_pc", 72'(pco[63:32]), 72'h1c000000);
    step(1, 32'h1c000010, 8'h00, 0, 0, 1);
    step(1, 32'h1c000010, 8'h00, 1, 0, 1);
    idle();
    chk("fullpop_count", 72'(cnt), 72'd3);
    chk("fullpop_head_pc", 72'(pco[63:32]), 72'h1c000004);
    step(1, 32'h1c000010, 8'h00, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h1c000020 + 32'(4 * i), 8'h00, 0, 0, 1);
    step(1, 32'h1c000030, 8'h00, 0, 1, 1);
    idle();
    chk("flush_count", 72'(cnt), 72'd0);
    chk("flush_valid", 72'(vout), 72'd0);
    chk("flush_empty", 72'(empty), 72'd1);
    chk("flush_allowin", 72'(allow), 72'd1);
    for (int i = 0; i < 2; i++) step(1, 32'h1c000040 + 32'(4 * i), 8'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      step(1, 32'h1c000048 + 32'(4 * i), (i == 4) ? 8'h08 : 8'h00, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 8'h00, 1, 0, 1);
`ifdef ID_IQ_BYPASS_EN
    vin = 1; pci = {32'h1c000020, 32'h0}; exi = 8'h00; ida = 1; flush = 0; rst_n = 1;
    #1;
    chk("byp_valid", 72'(vout), 72'd1);
    chk("byp_pc", 72'(pco[63:32]), 72'h1c000020);
    step(1, 32'h1c000020, 8'h00, 1, 0, 1);
    idle();
    chk("byp_count", 72'(cnt), 72'd0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 32'h1c000000 + 32'($urandom_range(0, 4095) * 4),
           8'($urandom), $urandom_range(0, (i / 500) % 2 ? 1 : 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 199) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
